// File: rtl/msrv32_pc_fetch.sv
// msrv32 program-counter and instruction-fetch stage: one outstanding fetch over a
// req/gnt/rvalid handshake, with next-PC selection (trap > mret > branch > PC+4).
module msrv32_pc_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] iadder_in,
  input  logic        branch_taken_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  input  logic        trap_in,
  input  logic [31:0] trap_address_in,
  input  logic        stall_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic        misaligned_instr_out
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus_4;
  logic [31:0] r_instr;
  logic        r_kill;
  logic        r_req;
  logic        r_valid;

  state_t      w_state_nxt;
  logic        w_pc_load;
  logic [31:0] w_pc_nxt;
  logic        w_kill_nxt;
  logic        w_instr_load;
  logic        w_accept;
  logic        w_branch_misaligned;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_branch_target;

  assign w_accept            = (r_state == HOLD) && !stall_in;
  assign w_branch_target     = iadder_in & 32'hFFFF_FFFE;
  assign w_branch_misaligned = !trap_in && !mret_in && branch_taken_in && iadder_in[1];

  // Next-PC selection applied when the held instruction is accepted
  always_comb begin
    w_redirect_pc = r_pc_plus_4;
    if (trap_in) begin
      w_redirect_pc = trap_address_in;
    end else if (mret_in) begin
      w_redirect_pc = epc_in;
    end else if (branch_taken_in) begin
      w_redirect_pc = w_branch_target;
    end else begin
      w_redirect_pc = r_pc_plus_4;
    end
  end

  // Fetch state machine next-state, PC load and kill bookkeeping
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_load    = 1'b0;
    w_pc_nxt     = r_pc;
    w_kill_nxt   = r_kill;
    w_instr_load = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
        if (trap_in) begin
          w_pc_load = 1'b1;
          w_pc_nxt  = trap_address_in;
        end else begin
          w_pc_load = 1'b0;
        end
      end
      REQ: begin
        if (trap_in) begin
          w_pc_load = 1'b1;
          w_pc_nxt  = trap_address_in;
          // a grant taken alongside the trap is for the old address: drop its response
          if (imem_gnt_in) begin
            w_state_nxt = WAIT;
            w_kill_nxt  = 1'b1;
          end else begin
            w_state_nxt = REQ;
          end
        end else if (imem_gnt_in) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = REQ;
        end
      end
      WAIT: begin
        if (trap_in) begin
          w_pc_load = 1'b1;
          w_pc_nxt  = trap_address_in;
        end else begin
          w_pc_load = 1'b0;
        end
        if (imem_rvalid_in) begin
          w_kill_nxt = 1'b0;
          if (r_kill || trap_in) begin
            w_state_nxt = REQ;
          end else begin
            w_instr_load = 1'b1;
            w_state_nxt  = HOLD;
          end
        end else if (trap_in) begin
          w_kill_nxt = 1'b1;
        end else begin
          w_kill_nxt = r_kill;
        end
      end
      HOLD: begin
        if (w_accept) begin
          if (w_branch_misaligned) begin
            w_state_nxt = HALT;
          end else begin
            w_pc_load   = 1'b1;
            w_pc_nxt    = w_redirect_pc;
            w_state_nxt = REQ;
          end
        end else if (trap_in) begin
          w_pc_load   = 1'b1;
          w_pc_nxt    = trap_address_in;
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      HALT: begin
        if (trap_in) begin
          w_pc_load   = 1'b1;
          w_pc_nxt    = trap_address_in;
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = HALT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_kill_nxt  = 1'b0;
      end
    endcase
  end

  // State, PC, instruction and handshake output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= IDLE;
      r_pc        <= BOOT_ADDR;
      r_pc_plus_4 <= BOOT_ADDR + 32'd4;
      r_instr     <= NOP_INSTR;
      r_kill      <= 1'b0;
      r_req       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
      r_req   <= (w_state_nxt == REQ);
      r_valid <= (w_state_nxt == HOLD);
      if (w_pc_load) begin
        r_pc        <= w_pc_nxt;
        r_pc_plus_4 <= w_pc_nxt + 32'd4;
      end
      if (w_instr_load) begin
        r_instr <= imem_rdata_in;
      end
    end
  end

  assign imem_req_out         = r_req;
  assign imem_addr_out        = r_pc;
  assign pc_out               = r_pc;
  assign pc_plus_4_out        = r_pc_plus_4;
  assign instr_out            = r_instr;
  assign instr_valid_out      = r_valid;
  assign misaligned_instr_out = w_accept && w_branch_misaligned;

endmodule

// File: tb/tb_msrv32_pc_fetch.sv
// Scoreboard bench for msrv32_pc_fetch: a small memory model answers fetches and
// expected {pc, instr} pairs are popped whenever a new instruction becomes valid.
module tb_msrv32_pc_fetch;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] iadder_in;
  logic        branch_taken_in;
  logic        mret_in;
  logic [31:0] epc_in;
  logic        trap_in;
  logic [31:0] trap_address_in;
  logic        stall_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] instr_out;
  logic        instr_valid_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4_out;
  logic        misaligned_instr_out;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        gnt_en;
  int          rv_delay;
  logic [31:0] m_addr;
  int          m_cnt;
  logic        m_busy;
  logic        prev_valid;

  msrv32_pc_fetch dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .iadder_in           (iadder_in),
    .branch_taken_in     (branch_taken_in),
    .mret_in             (mret_in),
    .epc_in              (epc_in),
    .trap_in             (trap_in),
    .trap_address_in     (trap_address_in),
    .stall_in            (stall_in),
    .imem_req_out        (imem_req_out),
    .imem_addr_out       (imem_addr_out),
    .imem_gnt_in         (imem_gnt_in),
    .imem_rvalid_in      (imem_rvalid_in),
    .imem_rdata_in       (imem_rdata_in),
    .instr_out           (instr_out),
    .instr_valid_out     (instr_valid_out),
    .pc_out              (pc_out),
    .pc_plus_4_out       (pc_plus_4_out),
    .misaligned_instr_out(misaligned_instr_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return {a[15:0], 16'h0013} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    sb_entry_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    sb_q.push_back(e);
  endtask

  task automatic wait_hold(input string tag);
    int n = 0;
    while (!instr_valid_out && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, instr_valid_out}, 32'd1);
  endtask

  // Memory: zero-wait grant when enabled, response rv_delay cycles after grant
  assign imem_gnt_in   = imem_req_out & gnt_en;
  assign imem_rdata_in = mem_word(m_addr);

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      imem_rvalid_in <= 1'b0;
      m_busy         <= 1'b0;
      m_cnt          <= 0;
      m_addr         <= 32'd0;
    end else begin
      imem_rvalid_in <= 1'b0;
      if (imem_req_out && imem_gnt_in) begin
        m_addr <= imem_addr_out;
        m_cnt  <= rv_delay - 1;
        if (rv_delay == 1) begin
          imem_rvalid_in <= 1'b1;
          m_busy         <= 1'b0;
        end else begin
          m_busy <= 1'b1;
        end
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          imem_rvalid_in <= 1'b1;
          m_busy         <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Scoreboard: each new valid instruction must match the oldest expectation
  always @(negedge clk_in) begin
    if (instr_valid_out && !prev_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        chk("sb_pc", pc_out, sb_q[0].pc);
        chk("sb_instr", instr_out, sb_q[0].instr);
        void'(sb_q.pop_front());
      end
    end
    prev_valid <= instr_valid_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic saw_valid;
    rst_n_in = 1'b0; iadder_in = 32'd0; branch_taken_in = 1'b0; mret_in = 1'b0;
    epc_in = 32'd0; trap_in = 1'b0; trap_address_in = 32'd0; stall_in = 1'b1;
    gnt_en = 1'b1; rv_delay = 1; prev_valid = 1'b0;
    repeat (2) tick();
    chk("rst_pc", pc_out, 32'h0000_0000);
    chk("rst_pc4", pc_plus_4_out, 32'h0000_0004);
    chk("rst_req", {31'd0, imem_req_out}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_out}, 32'd0);
    chk("rst_instr", instr_out, 32'h0000_0013);
    chk("rst_mis", {31'd0, misaligned_instr_out}, 32'd0);

    // boot fetch with zero-wait memory
    push(32'h0000_0000);
    rst_n_in = 1'b1;
    tick();
    chk("t0_req", {31'd0, imem_req_out}, 32'd1);
    chk("t0_addr", imem_addr_out, 32'h0000_0000);
    chk("t0_valid", {31'd0, instr_valid_out}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, instr_valid_out}, 32'd0);
    tick();
    chk("t2_valid", {31'd0, instr_valid_out}, 32'd1);
    chk("t2_instr", instr_out, 32'h0050_0093);
    chk("t2_pc4", pc_plus_4_out, 32'h0000_0004);

    // sequential accept, then stall in HOLD
    push(32'h0000_0004);
    stall_in = 1'b0; tick(); stall_in = 1'b1;
    chk("acc_pc4", pc_out, 32'h0000_0004);
    wait_hold("hold_4");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr_out, mem_word(32'h0000_0004));
      chk("stall_pc", pc_out, 32'h0000_0004);
    end
    push(32'h0000_0008);
    stall_in = 1'b0; tick(); stall_in = 1'b1;
    chk("rel_pc", pc_out, 32'h0000_0008);
    wait_hold("hold_8");

    // aligned branch, bit 0 cleared
    push(32'h0000_0100);
    branch_taken_in = 1'b1; iadder_in = 32'h0000_0101; stall_in = 1'b0;
    #1;
    chk("br_mis", {31'd0, misaligned_instr_out}, 32'd0);
    tick(); branch_taken_in = 1'b0; stall_in = 1'b1;
    chk("br_pc", pc_out, 32'h0000_0100);
    chk("br_pc4", pc_plus_4_out, 32'h0000_0104);
    wait_hold("hold_100");

    // misaligned branch halts, trap recovers
    branch_taken_in = 1'b1; iadder_in = 32'h0000_0102; stall_in = 1'b0;
    #1;
    chk("mis_pulse", {31'd0, misaligned_instr_out}, 32'd1);
    tick(); branch_taken_in = 1'b0; stall_in = 1'b1;
    chk("mis_drop", {31'd0, misaligned_instr_out}, 32'd0);
    chk("halt_pc", pc_out, 32'h0000_0100);
    chk("halt_valid", {31'd0, instr_valid_out}, 32'd0);
    tick();
    chk("halt_req", {31'd0, imem_req_out}, 32'd0);
    push(32'h0000_0200);
    trap_in = 1'b1; trap_address_in = 32'h0000_0200;
    tick(); trap_in = 1'b0;
    chk("halt_trap_pc", pc_out, 32'h0000_0200);
    chk("halt_trap_addr", imem_addr_out, 32'h0000_0200);
    chk("halt_trap_req", {31'd0, imem_req_out}, 32'd1);
    wait_hold("hold_200");

    // trap while waiting on a slow response
    rv_delay = 3;
    stall_in = 1'b0; tick(); stall_in = 1'b1;
    tick();
    trap_in = 1'b1; trap_address_in = 32'h0000_0040;
    tick(); trap_in = 1'b0;
    chk("wait_trap_pc", pc_out, 32'h0000_0040);
    push(32'h0000_0040);
    n = 0; saw_valid = 1'b0;
    while (!imem_req_out && n < 20) begin
      tick();
      saw_valid = saw_valid | instr_valid_out;
      n++;
    end
    rv_delay = 1;
    chk("kill_no_valid", {31'd0, saw_valid}, 32'd0);
    chk("kill_req", {31'd0, imem_req_out}, 32'd1);
    chk("kill_addr", imem_addr_out, 32'h0000_0040);
    wait_hold("hold_40");

    // mret beats branch; trap beats both
    push(32'h0000_0080);
    mret_in = 1'b1; branch_taken_in = 1'b1; epc_in = 32'h0000_0080; iadder_in = 32'h0000_0300;
    stall_in = 1'b0; tick(); stall_in = 1'b1; mret_in = 1'b0; branch_taken_in = 1'b0;
    chk("mret_pc", pc_out, 32'h0000_0080);
    wait_hold("hold_80");
    push(32'h0000_0240);
    trap_in = 1'b1; mret_in = 1'b1; branch_taken_in = 1'b1; trap_address_in = 32'h0000_0240;
    stall_in = 1'b0; tick(); stall_in = 1'b1;
    trap_in = 1'b0; mret_in = 1'b0; branch_taken_in = 1'b0;
    chk("trap_prio_pc", pc_out, 32'h0000_0240);
    wait_hold("hold_240");

    // trap in REQ without grant retargets the request
    gnt_en = 1'b0;
    stall_in = 1'b0; tick(); stall_in = 1'b1;
    tick();
    chk("req_nognt_addr", imem_addr_out, 32'h0000_0244);
    trap_in = 1'b1; trap_address_in = 32'h0000_0060;
    tick(); trap_in = 1'b0;
    chk("req_trap_addr", imem_addr_out, 32'h0000_0060);
    chk("req_trap_req", {31'd0, imem_req_out}, 32'd1);
    push(32'h0000_0060);
    gnt_en = 1'b1;
    wait_hold("hold_60");

    // trap in HOLD under stall drops the held instruction
    trap_in = 1'b1; trap_address_in = 32'h0000_0070;
    tick(); trap_in = 1'b0;
    chk("hold_trap_valid", {31'd0, instr_valid_out}, 32'd0);
    chk("hold_trap_pc", pc_out, 32'h0000_0070);
    push(32'h0000_0070);
    wait_hold("hold_70");

    // reset mid-fetch clears everything asynchronously
    rv_delay = 3;
    stall_in = 1'b0; tick(); stall_in = 1'b1;
    tick();
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_pc", pc_out, 32'h0000_0000);
    chk("mid_rst_req", {31'd0, imem_req_out}, 32'd0);
    chk("mid_rst_instr", instr_out, 32'h0000_0013);
    tick();
    rst_n_in = 1'b1; rv_delay = 1;
    push(32'h0000_0000);
    wait_hold("hold_reboot");
    tick();

    chk("sb_leftover", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/msrv32_pc_fetch.md
# msrv32_pc_fetch

Program-counter and instruction-fetch stage of the msrv32 core. It holds the architectural PC and fetches one instruction at a time over a request/grant/rvalid memory handshake. It presents each fetched instruction to decode and computes the next PC when that instruction is accepted. The next PC is PC+4, the branch/jump target from the immediate adder's iadder output, the mret return address, or the trap vector, chosen by priority.

## Interface
- BOOT_ADDR, 32'h0000_0000, PC value after reset (must be word-aligned).
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- iadder_in  input  32  branch/jump target from the immediate adder.
- branch_taken_in  input  1  the accepted instruction redirects to iadder_in.
- mret_in  input  1  the accepted instruction returns to epc_in.
- epc_in  input  32  return address for mret.
- trap_in  input  1  trap request; valid in any cycle.
- trap_address_in  input  32  trap vector (mtvec-derived).
- stall_in  input  1  downstream not accepting this cycle.
- imem_req_out  output  1  fetch request.
- imem_addr_out  output  32  fetch address; always equals pc_out.
- imem_gnt_in  input  1  address accepted.
- imem_rvalid_in  input  1  imem_rdata_in valid.
- imem_rdata_in  input  32  fetched word.
- instr_out  output  32  held instruction.
- instr_valid_out  output  1  instr_out valid.
- pc_out  output  32  PC of the instruction being fetched or held.
- pc_plus_4_out  output  32  pc_out + 4, modulo 2^32.
- misaligned_instr_out  output  1  redirect target not 4-byte aligned.

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT. One fetch outstanding at most.
- IDLE: entered only from reset. Moves to REQ on the next clock edge.
- REQ: imem_req_out=1. On imem_gnt_in, moves to WAIT. Address is stable until grant.
- WAIT: on imem_rvalid_in, captures imem_rdata_in into instr_out and moves to HOLD. rvalid in the same cycle as gnt is not legal (memory latency is at least 1).
- HOLD: instr_valid_out=1. Accept occurs when stall_in=0. On accept, the PC updates and the state moves to REQ.
- Next-PC priority at accept:
  - trap_in: trap_address_in.
  - mret_in: epc_in.
  - branch_taken_in: {iadder_in[31:1],1'b0}.
  - otherwise: pc_out+4.
- Misaligned redirect: applies when the branch is selected and iadder_in[1]=1.
  - misaligned_instr_out pulses for the accept cycle.
  - PC is not updated.
  - State moves to HALT, with instr_valid_out=0 and imem_req_out=0.
  - HALT exits only on trap_in, which loads trap_address_in and moves to REQ.
- trap_in outside an accept cycle loads pc from trap_address_in:
  - In REQ: retargets next cycle. No grant was taken that cycle, or a grant in the same cycle is treated as a kill.
  - In WAIT: sets the kill flag. The pending response is discarded on arrival, then the state moves to REQ.
  - In HOLD under stall: the held instruction is dropped; state moves to REQ.
  - In IDLE: takes effect.
- The kill flag clears when its response arrives. trap_address_in and epc_in are used without masking.

## Timing
- Reset values while rst_n_in=0:
  - state=IDLE, pc_out=BOOT_ADDR, pc_plus_4_out=BOOT_ADDR+4.
  - imem_req_out=0, instr_valid_out=0, instr_out=32'h0000_0013 (NOP), misaligned_instr_out=0, kill=0.
- Reset asserted mid-fetch: all state is cleared immediately. A late rvalid after reset release is ignored, because the state machine is in IDLE or REQ.
- Fetch latency with a zero-wait memory (gnt in the request cycle, rvalid one cycle later): REQ at T0, WAIT at T1, HOLD at T2 with instr_valid_out=1. Best case is 1 instruction per 3 cycles.
- pc_out and pc_plus_4_out are registered and change only on the accept edge, on a trap edge, or on reset.
- misaligned_instr_out is combinational from the HOLD state, accept, branch_taken_in and iadder_in[1].

## Test plan
- Reset with BOOT_ADDR=0 and zero-wait memory returning 32'h00500093 -> imem_addr_out=0, instr_valid_out at cycle 2, instr_out=32'h00500093, next addr 4.
- HOLD with stall_in=1 for 3 cycles, then released -> instr_out is stable, pc_out=0x4 is unchanged until release, then pc_out=0x8.
- Accept with branch_taken_in=1, iadder_in=32'h0000_0101 -> pc_out=32'h0000_0100; misaligned_instr_out=0.
- Accept with branch_taken_in=1, iadder_in=32'h0000_0102 -> misaligned_instr_out=1 for one cycle, state HALT, PC unchanged. Then trap_in=1 with trap_address_in=32'h0000_0200 -> next fetch at 0x200.
- trap_in in WAIT (rvalid delayed 3 cycles), trap_address_in=32'h0000_0040 -> the stale response is dropped, instr_valid_out stays 0, the next request address is 0x40.
- Accept with mret_in=1, branch_taken_in=1, epc_in=32'h0000_0080 -> pc_out=0x80 (mret beats branch). With trap_in also asserted, trap wins.
